// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive buffer behind uart_receiver.
// Each entry holds {err, data}. The block reports occupancy, a sticky overrun
// flag and a level-threshold interrupt. flush clears contents and flags on the
// next clock edge.
module uart_rx_fifo #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ADDR_W    = 4
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 flush,
    input  logic                 wr_valid,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 wr_err,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_err,
    output logic                 empty,
    output logic                 full,
    output logic [ADDR_W:0]      count,
    input  logic [ADDR_W:0]      thresh,
    output logic                 level_irq,
    output logic                 overrun,
    input  logic                 overrun_clr
);

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [DATA_BITS:0]  mem_r [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_r;
    logic [ADDR_W-1:0]   rd_ptr_r;
    logic [ADDR_W:0]     count_r;
    logic                empty_r;
    logic                full_r;
    logic                overrun_r;

    logic                pop_ok_s;
    logic                push_ok_s;
    logic                overflow_s;
    logic [ADDR_W:0]     count_nxt_s;

    // Accept/drop decisions; a pop frees a slot for a same-cycle push when full.
    always_comb begin
        pop_ok_s   = rd_en & ~empty_r;
        push_ok_s  = wr_valid & (~full_r | pop_ok_s);
        overflow_s = wr_valid & full_r & ~pop_ok_s;
    end

    // Next occupancy: push-only adds one, pop-only removes one, both cancel.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Entry storage; the array is deliberately left out of reset.
    always_ff @(posedge PCLK) begin
        if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r] <= {wr_err, wr_data};
        end
    end

    // Pointers, occupancy and registered empty/full flags; flush overrides all.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr_r <= {ADDR_W{1'b0}};
            rd_ptr_r <= {ADDR_W{1'b0}};
            count_r  <= {(ADDR_W+1){1'b0}};
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else if (flush) begin
            wr_ptr_r <= {ADDR_W{1'b0}};
            rd_ptr_r <= {ADDR_W{1'b0}};
            count_r  <= {(ADDR_W+1){1'b0}};
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
            empty_r <= (count_nxt_s == {(ADDR_W+1){1'b0}});
            full_r  <= (count_nxt_s == FULL_CNT);
        end
    end

    // Sticky overrun: flush beats a new overflow, which beats overrun_clr.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            overrun_r <= 1'b0;
        end else if (flush) begin
            overrun_r <= 1'b0;
        end else if (overflow_s) begin
            overrun_r <= 1'b1;
        end else if (overrun_clr) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    // Output mapping: FWFT head entry and threshold interrupt (0 disables).
    always_comb begin
        rd_data   = mem_r[rd_ptr_r][DATA_BITS-1:0];
        rd_err    = mem_r[rd_ptr_r][DATA_BITS];
        empty     = empty_r;
        full      = full_r;
        count     = count_r;
        overrun   = overrun_r;
        level_irq = (thresh != {(ADDR_W+1){1'b0}}) && (count_r >= thresh);
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo with hand-computed expectations.
module tb_uart_rx_fifo;

    logic       PCLK;
    logic       PRESETn;
    logic       flush;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_err;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_err;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic [4:0] thresh;
    logic       level_irq;
    logic       overrun;
    logic       overrun_clr;

    int n_cmp;
    int n_fail;

    uart_rx_fifo #(.DATA_BITS(8), .DEPTH(16), .ADDR_W(4)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .flush(flush),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_err(wr_err),
        .rd_en(rd_en), .rd_data(rd_data), .rd_err(rd_err),
        .empty(empty), .full(full), .count(count), .thresh(thresh),
        .level_irq(level_irq), .overrun(overrun), .overrun_clr(overrun_clr)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Stimulus helpers: apply inputs for one edge, then sample 1 time unit later.
    task automatic push(input logic [7:0] b, input logic e);
        wr_valid = 1'b1; wr_data = b; wr_err = e;
        @(posedge PCLK); #1;
        wr_valid = 1'b0; wr_err = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(posedge PCLK); #1;
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
        n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", full); end
        n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b exp 0", overrun); end
        n_cmp++; if (level_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b exp 0", level_irq); end
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
    endtask

    task automatic test_basic();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h16; exp_b[1] = 8'h32; exp_b[2] = 8'hAF;
        for (int i = 0; i < 3; i++) push(exp_b[i], 1'b0);
        n_cmp++; if (count !== 5'd3) begin n_fail++; $display("FAIL basic_count got %0d exp 3", count); end
        n_cmp++; if (empty !== 1'b0) begin n_fail++; $display("FAIL basic_empty got %b exp 0", empty); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (rd_data !== exp_b[i]) begin n_fail++; $display("FAIL basic_data[%0d] got %h exp %h", i, rd_data, exp_b[i]); end
            pop();
        end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty_end got %b exp 1", empty); end
        n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL basic_count_end got %0d exp 0", count); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
        push(8'hAA, 1'b0);
        n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full got %b exp 1", full); end
        n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovf_overrun got %b exp 1", overrun); end
        n_cmp++; if (count !== 5'd16) begin n_fail++; $display("FAIL ovf_count got %0d exp 16", count); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (rd_data !== 8'(i)) begin n_fail++; $display("FAIL ovf_data[%0d] got %h exp %h", i, rd_data, 8'(i)); end
            pop();
        end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ovf_empty got %b exp 1", empty); end
        n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", overrun); end
        overrun_clr = 1'b1;
        @(posedge PCLK); #1;
        overrun_clr = 1'b0;
        n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got %b exp 0", overrun); end
    endtask

    task automatic test_full_pushpop();
        for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
        wr_valid = 1'b1; wr_data = 8'h55; rd_en = 1'b1;
        @(posedge PCLK); #1;
        wr_valid = 1'b0; rd_en = 1'b0;
        n_cmp++; if (count !== 5'd16) begin n_fail++; $display("FAIL fpp_count got %0d exp 16", count); end
        n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL fpp_overrun got %b exp 0", overrun); end
        for (int i = 1; i < 16; i++) begin
            n_cmp++; if (rd_data !== 8'(i)) begin n_fail++; $display("FAIL fpp_data[%0d] got %h exp %h", i, rd_data, 8'(i)); end
            pop();
        end
        n_cmp++; if (rd_data !== 8'h55) begin n_fail++; $display("FAIL fpp_last got %h exp 55", rd_data); end
        pop();
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fpp_empty got %b exp 1", empty); end
        wr_valid = 1'b1; wr_data = 8'h77; rd_en = 1'b1;
        @(posedge PCLK); #1;
        wr_valid = 1'b0; rd_en = 1'b0;
        n_cmp++; if (count !== 5'd1) begin n_fail++; $display("FAIL epp_count got %0d exp 1", count); end
        n_cmp++; if (rd_data !== 8'h77) begin n_fail++; $display("FAIL epp_data got %h exp 77", rd_data); end
        n_cmp++; if (empty !== 1'b0) begin n_fail++; $display("FAIL epp_empty got %b exp 0", empty); end
        pop();
    endtask

    task automatic test_level_irq();
        thresh = 5'd4;
        for (int i = 0; i < 3; i++) push(8'(8'h40 + i), 1'b0);
        n_cmp++; if (level_irq !== 1'b0) begin n_fail++; $display("FAIL irq_below got %b exp 0", level_irq); end
        push(8'h43, 1'b0);
        n_cmp++; if (level_irq !== 1'b1) begin n_fail++; $display("FAIL irq_at got %b exp 1", level_irq); end
        pop();
        n_cmp++; if (level_irq !== 1'b0) begin n_fail++; $display("FAIL irq_after_pop got %b exp 0", level_irq); end
        for (int i = 0; i < 3; i++) pop();
        thresh = 5'd0;
        for (int i = 0; i < 16; i++) begin
            push(8'(i), 1'b0);
            n_cmp++; if (level_irq !== 1'b0) begin n_fail++; $display("FAIL irq_disabled[%0d] got %b exp 0", i, level_irq); end
        end
        for (int i = 0; i < 16; i++) pop();
        n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL irq_drain got %0d exp 0", count); end
    endtask

    task automatic test_err_tag();
        push(8'hAF, 1'b1);
        push(8'h32, 1'b0);
        n_cmp++; if (rd_err !== 1'b1) begin n_fail++; $display("FAIL err_head got %b exp 1", rd_err); end
        n_cmp++; if (rd_data !== 8'hAF) begin n_fail++; $display("FAIL err_head_data got %h exp af", rd_data); end
        pop();
        n_cmp++; if (rd_err !== 1'b0) begin n_fail++; $display("FAIL err_second got %b exp 0", rd_err); end
        n_cmp++; if (rd_data !== 8'h32) begin n_fail++; $display("FAIL err_second_data got %h exp 32", rd_data); end
        pop();
        pop();
        n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL empty_pop_count got %0d exp 0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL empty_pop_empty got %b exp 1", empty); end
        push(8'h11, 1'b0);
        n_cmp++; if (rd_data !== 8'h11) begin n_fail++; $display("FAIL empty_pop_ptr got %h exp 11", rd_data); end
        n_cmp++; if (count !== 5'd1) begin n_fail++; $display("FAIL empty_pop_count2 got %0d exp 1", count); end
        pop();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 16; i++) push(8'(8'h80 + i), 1'b0);
        wr_valid = 1'b1; wr_data = 8'hEE; overrun_clr = 1'b1;
        @(posedge PCLK); #1;
        wr_valid = 1'b0; overrun_clr = 1'b0;
        n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL set_beats_clr got %b exp 1", overrun); end
        for (int i = 0; i < 11; i++) pop();
        n_cmp++; if (count !== 5'd5) begin n_fail++; $display("FAIL flush_pre_count got %0d exp 5", count); end
        flush = 1'b1; wr_valid = 1'b1; wr_data = 8'h99;
        @(posedge PCLK); #1;
        flush = 1'b0; wr_valid = 1'b0;
        n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL flush_count got %0d exp 0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL flush_empty got %b exp 1", empty); end
        n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL flush_overrun got %b exp 0", overrun); end
        push(8'h42, 1'b0);
        n_cmp++; if (rd_data !== 8'h42) begin n_fail++; $display("FAIL flush_next_data got %h exp 42", rd_data); end
        n_cmp++; if (count !== 5'd1) begin n_fail++; $display("FAIL flush_next_count got %0d exp 1", count); end
        pop();
    endtask

    task automatic test_async_reset();
        thresh = 5'd4;
        for (int i = 0; i < 7; i++) push(8'(8'h20 + i), 1'b0);
        n_cmp++; if (count !== 5'd7) begin n_fail++; $display("FAIL ar_pre_count got %0d exp 7", count); end
        n_cmp++; if (level_irq !== 1'b1) begin n_fail++; $display("FAIL ar_pre_irq got %b exp 1", level_irq); end
        #2;
        PRESETn = 1'b0;
        #1;
        n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL ar_count got %0d exp 0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ar_empty got %b exp 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL ar_full got %b exp 0", full); end
        n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ar_overrun got %b exp 0", overrun); end
        n_cmp++; if (level_irq !== 1'b0) begin n_fail++; $display("FAIL ar_irq got %b exp 0", level_irq); end
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        push(8'h5A, 1'b0);
        n_cmp++; if (rd_data !== 8'h5A) begin n_fail++; $display("FAIL ar_after_data got %h exp 5a", rd_data); end
        thresh = 5'd0;
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        PRESETn = 1'b0; flush = 1'b0; wr_valid = 1'b0; wr_data = 8'h00;
        wr_err = 1'b0; rd_en = 1'b0; thresh = 5'd0; overrun_clr = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_full_pushpop();
        test_level_irq();
        test_err_tag();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
